// File: rtl/sine_dds_pkg.sv
// Shared types and defaults for the sine DDS controller: FSM encoding, default widths, dither LFSR constants.
package sine_dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dds_state_e;

  localparam int PW_DEF = 16;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/sine_dds_ctrl_if.sv
// Table-write handshake plus the single RAM port; master = controller side, slave = host/RAM side.
interface sine_dds_ctrl_if
  import sine_dds_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_qout;

  modport master (
    input  wr_valid, wr_addr, wr_data, mem_qout,
    output wr_ready, mem_addr, mem_we, mem_din
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, mem_qout,
    input  wr_ready, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/sine_dds_ctrl_phase_acc.sv
// Tuning register and phase accumulator producing the truncated table address (combinational from phase).
// DDS_DITHER_EN adds LFSR dither to the address only; the accumulator itself stays exact.
module dds_phase_acc
  import sine_dds_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] tune_in,
  input  logic          tune_ld,
  input  logic          en,
  output logic [AW-1:0] addr
);

  logic [PW-1:0] tune_q;
  logic [PW-1:0] phase_q;

  // a tune load takes effect on the accumulate after the loading cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tune_q  <= '0;
      phase_q <= '0;
    end else begin
      if (tune_ld) tune_q <= tune_in;
      if (en) phase_q <= phase_q + tune_q;
    end
  end

`ifdef DDS_DITHER_EN
  localparam int DB = (PW - AW < 8) ? (PW - AW) : 8;

  logic [7:0]    lfsr_q;
  logic [PW-1:0] phase_dith;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else if (en) lfsr_q <= {lfsr_q[6:0], lfsr_fb(lfsr_q)};
  end

  assign phase_dith = phase_q + PW'(lfsr_q[DB-1:0]);
  assign addr       = phase_dith[PW-1 -: AW];
`else
  assign addr = phase_q[PW-1 -: AW];
`endif

endmodule

// File: rtl/sine_dds_ctrl.sv
// NCO/DDS front end for a 256x8 sine RAM: table loads while idle, phase-driven reads while running.
// Sample latency RD_LAT+1 from address issue; optional address dither under DDS_DITHER_EN.
module sine_dds_ctrl
  import sine_dds_pkg::*;
#(
  parameter int PW     = PW_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PW-1:0]    tune_in,
  input  logic             tune_ld,
  input  logic             run,
  sine_dds_ctrl_if.master  bus,
  output logic [DW-1:0]    samp,
  output logic             samp_valid,
  output logic             busy
);

  localparam int CW = $clog2(RD_LAT + 1) + 1;

  dds_state_e     state_q, state_d;
  logic [CW-1:0]  drain_cnt;
  logic [RD_LAT:0] rd_pipe;
  logic [AW-1:0]  acc_addr;
  logic           acc_en;
  logic           wr_fire;

  dds_phase_acc #(.PW(PW), .AW(AW)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .tune_in (tune_in),
    .tune_ld (tune_ld),
    .en      (acc_en),
    .addr    (acc_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drain_cnt <= '0;
    end else begin
      state_q   <= state_d;
      drain_cnt <= (state_q == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // DRAIN runs RD_LAT+1 cycles so the last issued read lands in samp before IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = DRAIN;
      DRAIN:   if (drain_cnt == CW'(RD_LAT)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_fire      = (state_q == IDLE) && bus.wr_valid;
    acc_en       = (state_q == RUN);
    busy         = (state_q != IDLE);
    bus.wr_ready = (state_q == IDLE);
    bus.mem_we   = wr_fire;
    bus.mem_addr = acc_addr;
    bus.mem_din  = '0;
    if (wr_fire) begin
      bus.mem_addr = bus.wr_addr;
      bus.mem_din  = bus.wr_data;
    end
  end

  // one bit per RUN cycle marks which RAM outputs are real samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe <= '0;
      samp    <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LAT-1:0], acc_en};
      if (rd_pipe[RD_LAT-1]) samp <= bus.mem_qout;
    end
  end

  assign samp_valid = rd_pipe[RD_LAT];

endmodule

// File: tb/tb_sine_dds_ctrl.sv
// Bench for sine_dds_ctrl: behavioural RAM, cycle model of the DDS rules, per-cycle scoreboard plus scenario tasks.
module tb_sine_dds_ctrl;
  localparam int PW = 16, AW = 8, DW = 8, RD_LAT = 1;
`ifdef DDS_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] tune_in = '0;
  logic          tune_ld = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] samp;
  logic          samp_valid, busy;

  sine_dds_ctrl_if #(.AW(AW), .DW(DW)) bus_if ();

  sine_dds_ctrl #(.PW(PW), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .tune_in(tune_in), .tune_ld(tune_ld), .run(run),
    .bus(bus_if), .samp(samp), .samp_valid(samp_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // 256x8 RAM with registered read data
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    bus_if.mem_qout <= ram[bus_if.mem_addr];
    if (bus_if.mem_we === 1'b1) ram[bus_if.mem_addr] = bus_if.mem_din;
  end

  // ---------------- reference model ----------------
  typedef struct { bit v; logic [AW-1:0] a; } iss_t;
  iss_t          iss_q[$];
  logic [DW-1:0] tbl [256];
  int            m_st;      // 0 idle, 1 playing, 2 draining
  int            m_drain;
  logic [PW-1:0] m_phase, m_tune;
  bit            e_valid;
  logic [DW-1:0] e_mid, e_lo, e_hi;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_drain = 0; m_phase = '0; m_tune = '0;
      iss_q.delete(); e_valid = 0; e_mid = '0; e_lo = '0; e_hi = '0;
    end else begin
      iss_t it, o;
      it.v = (m_st == 1);
      it.a = m_phase[PW-1 -: AW];
      iss_q.push_back(it);
      e_valid = 0;
      while (iss_q.size() > RD_LAT) begin
        o = iss_q.pop_front();
        e_valid = o.v;
        if (o.v) begin
          e_mid = tbl[o.a];
          e_lo  = tbl[AW'(o.a - 1)];
          e_hi  = tbl[AW'(o.a + 1)];
        end
      end
      if (m_st == 0 && bus_if.wr_valid === 1'b1) tbl[bus_if.wr_addr] = bus_if.wr_data;
      case (m_st)
        0: if (run) m_st = 1;
        1: begin
          m_phase = m_phase + m_tune;
          if (!run) begin m_st = 2; m_drain = RD_LAT + 1; end
        end
        default: begin
          m_drain--;
          if (m_drain == 0) m_st = 0;
        end
      endcase
      if (tune_ld) m_tune = tune_in;
    end
  end

  function automatic bit near(input logic [AW-1:0] act, input logic [AW-1:0] exp);
    logic [AW-1:0] d;
    d = act - exp;
    return (d == '0) || (DITHER && (d == AW'(1) || d == '1));
  endfunction

  // ---------------- per-cycle scoreboard ----------------
  bit            c_we;
  logic [AW-1:0] c_addr;
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      c_we   = (m_st == 0) && (bus_if.wr_valid === 1'b1);
      c_addr = c_we ? bus_if.wr_addr : m_phase[PW-1 -: AW];
      n_cmp++;
      if (busy !== (m_st != 0) || bus_if.wr_ready !== (m_st == 0)) begin
        n_err++;
        $display("FAIL state_flags @%0t: busy=%b wr_ready=%b, required busy=%b wr_ready=%b", $time, busy, bus_if.wr_ready, m_st != 0, m_st == 0);
      end
      n_cmp++;
      if (bus_if.mem_we !== c_we) begin
        n_err++; $display("FAIL mem_we @%0t: got %b required %b", $time, bus_if.mem_we, c_we);
      end
      n_cmp++;
      if (c_we ? (bus_if.mem_addr !== c_addr || bus_if.mem_din !== bus_if.wr_data) : !near(bus_if.mem_addr, c_addr)) begin
        n_err++; $display("FAIL mem_addr @%0t: got %h/%h required %h/%h", $time, bus_if.mem_addr, bus_if.mem_din, c_addr, bus_if.wr_data);
      end
      n_cmp++;
      if (samp_valid !== e_valid) begin
        n_err++; $display("FAIL samp_valid @%0t: got %b required %b", $time, samp_valid, e_valid);
      end
      n_cmp++;
      if (!(samp === e_mid || (DITHER && (samp === e_lo || samp === e_hi)))) begin
        n_err++; $display("FAIL samp @%0t: got %h required %h", $time, samp, e_mid);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || samp_valid !== 1'b0 || bus_if.mem_we !== 1'b0 || bus_if.wr_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_flags: busy=%b samp_valid=%b mem_we=%b wr_ready=%b required 0 0 0 1", busy, samp_valid, bus_if.mem_we, bus_if.wr_ready);
    end
    n_cmp++;
    if (samp !== 8'h00 || bus_if.mem_addr !== 8'h00) begin
      n_err++; $display("FAIL reset_data: samp=%h mem_addr=%h required 00 00", samp, bus_if.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_table_load();
    logic [7:0] wa [5];
    logic [7:0] wd [5];
    wa = '{8'h01, 8'h03, 8'h06, 8'h0A, 8'h0F};
    wd = '{8'h10, 8'h30, 8'h60, 8'hA0, 8'hF0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.wr_valid = 1'b1; bus_if.wr_addr = wa[i]; bus_if.wr_data = wd[i];
      #1;
      n_cmp++;
      if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== wa[i] || bus_if.mem_din !== wd[i] || bus_if.wr_ready !== 1'b1) begin
        n_err++; $display("FAIL table_write[%0d]: we=%b addr=%h din=%h rdy=%b required 1 %h %h 1", i, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_din, bus_if.wr_ready, wa[i], wd[i]);
      end
    end
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic test_playback();
    logic [7:0] exp7 [7];
    int got = 0, lat = 0;
    exp7 = '{8'h00, 8'h10, 8'h00, 8'h30, 8'h00, 8'h00, 8'h60};
    tune_in = 16'h0100; tune_ld = 1'b1;
    @(negedge clk);
    tune_ld = 1'b0; run = 1'b1;
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk);
      #1;
      if (samp_valid && lat == 0) lat = k;
      if (samp_valid && got < 7) begin
        n_cmp++;
        if (samp !== exp7[got]) begin
          n_err++; $display("FAIL play_samp[%0d]: got %h required %h", got, samp, exp7[got]);
        end
        got++;
      end
      if (k == 256 || k == 257) begin
        n_cmp++;
        if (bus_if.mem_addr !== 8'(k - 1)) begin
          n_err++; $display("FAIL addr_wrap k=%0d: got %h required %h", k, bus_if.mem_addr, 8'(k - 1));
        end
      end
    end
    n_cmp++;
    if (lat - 1 !== 2) begin
      n_err++; $display("FAIL first_sample_latency: got %0d cycles required 2", lat - 1);
    end
  endtask

  task automatic test_stop();
    int pulses = 0;
    @(negedge clk);
    run = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) run = 1'b1;   // ignored while draining
      #1;
      if (samp_valid) pulses++;
      if (k == 3) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL drain_end_busy: got %b required 0", busy);
        end
      end
    end
    n_cmp++;
    if (pulses !== 2) begin
      n_err++; $display("FAIL drain_pulses: got %0d required 2", pulses);
    end
    repeat (10) @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL stop_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_fractional();
    logic [7:0] a0, a1;
    @(negedge clk);
    tune_in = 16'h0080; tune_ld = 1'b1;
    @(negedge clk);
    tune_ld = 1'b0; run = 1'b1;
    repeat (20) @(negedge clk);
    tune_in = 16'h0200; tune_ld = 1'b1;
    @(negedge clk);
    tune_ld = 1'b0;
    #1 a0 = bus_if.mem_addr;
    @(negedge clk);
    #1 a1 = bus_if.mem_addr;
    n_cmp++;
    if (!near(a1 - a0, 8'd2)) begin
      n_err++; $display("FAIL retune_stride: got %0d required 2", a1 - a0);
    end
    repeat (10) @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL frac_stop_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_write_block();
    @(negedge clk);
    tune_in = 16'($urandom); tune_ld = 1'b1;
    @(negedge clk);
    tune_ld = 1'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus_if.wr_valid = 1'b1; bus_if.wr_addr = 8'($urandom); bus_if.wr_data = 8'($urandom);
      #1;
      n_cmp++;
      if (bus_if.wr_ready !== 1'b0 || bus_if.mem_we !== 1'b0) begin
        n_err++; $display("FAIL write_blocked: wr_ready=%b mem_we=%b required 0 0", bus_if.wr_ready, bus_if.mem_we);
      end
      @(negedge clk);
    end
    bus_if.wr_valid = 1'b0; run = 1'b0;
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    run = 1'b1;   // resumes from the saved phase
    repeat (8) @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL restart_stop_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    tune_in = 16'h0300; tune_ld = 1'b1;
    @(negedge clk);
    tune_ld = 1'b0; run = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bus_if.mem_addr !== 8'h00 || bus_if.wr_ready !== 1'b1) begin
      n_err++; $display("FAIL midrun_reset: busy=%b mem_addr=%h wr_ready=%b required 0 00 1", busy, bus_if.mem_addr, bus_if.wr_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (samp_valid !== 1'b0) begin
        n_err++; $display("FAIL aborted_read_pulse[%0d]: samp_valid=%b required 0", k, samp_valid);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    int n, pulses;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      bus_if.wr_valid = 1'b1; bus_if.wr_addr = 8'(i); bus_if.wr_data = 8'($urandom);
      @(negedge clk);
    end
    bus_if.wr_valid = 1'b0;
    for (int ep = 0; ep < 8; ep++) begin
      tune_in = (ep == 3) ? 16'h0000 : 16'($urandom); tune_ld = 1'b1;
      @(negedge clk);
      tune_ld = 1'b0; run = 1'b1;
      n = $urandom_range(1, 60);
      pulses = 0;
      for (int j = 1; j <= n + 8; j++) begin
        @(negedge clk);
        if (j == n) run = 1'b0;
        tune_ld = (j < n) && ($urandom_range(0, 9) == 0) && (ep != 3);
        tune_in = 16'($urandom);
        bus_if.wr_valid = (j < n) && ($urandom_range(0, 3) == 0);
        bus_if.wr_addr = 8'($urandom); bus_if.wr_data = 8'($urandom);
        #1;
        if (samp_valid) pulses++;
        if (j > n && !busy) break;
      end
      tune_ld = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || pulses !== n) begin
        n_err++; $display("FAIL episode[%0d]: busy=%b pulses=%0d required busy=0 pulses=%0d", ep, busy, pulses, n);
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      tbl[i] = '0;
    end
    bus_if.wr_valid = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
    test_reset();
    test_table_load();
    test_playback();
    test_stop();
    test_fractional();
    test_write_block();
    test_reset_midrun();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sine_dds_ctrl.md
Name: sine_dds_ctrl

Overview:
- Upstream driver for the 256x8 single-port sine table RAM (ports clk/addr/we/din/qout).
- Owns the RAM's single port and uses it for two jobs:
  - Table loading: host write handshake while idle.
  - Playback: a phase accumulator generates read addresses and returns a streamed sample with a valid flag.
- Turns a static sine table into a frequency-programmable NCO/DDS source.

Parameters:
- PW, 16, phase accumulator / tuning word width
- AW, 8, RAM address width; mem_addr = phase[PW-1 -: AW]; PW > AW required
- DW, 8, RAM data / sample width
- RD_LAT, 1, RAM read latency in cycles; qout is registered inside the RAM

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  synchronous reset, active-low
- tune_in  in  PW  phase increment (tuning word)
- tune_ld  in  1  load tune_in into the tuning register this cycle
- run  in  1  level; 1 = play, 0 = stop
- wr_valid  in  1  host table-write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  AW  table write address
- wr_data  in  DW  table write data
- mem_addr  out  AW  to RAM addr
- mem_we  out  1  to RAM we
- mem_din  out  DW  to RAM din
- mem_qout  in  DW  from RAM qout
- samp  out  DW  output sample
- samp_valid  out  1  samp is new this cycle
- busy  out  1  state != IDLE

Behaviour:
Interface:
- One clock, clk.
- rst_n is synchronous, active-low.
- All state updates on posedge clk.

Reset:
- state = IDLE.
- Phase, tuning register, mem_addr, mem_din, samp: all 0.
- mem_we, samp_valid, busy: 0.
- wr_ready: 1 (IDLE).
- Reset mid-RUN aborts immediately. Any in-flight reads are discarded: samp_valid stays 0.

FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - wr_ready = 1.
  - On wr_valid: the write is driven combinationally to the RAM in the same cycle: mem_we = 1, mem_addr = wr_addr, mem_din = wr_data.
  - Otherwise mem_we = 0 and mem_addr = phase[PW-1 -: AW].
  - run = 1 -> RUN next cycle. If run and wr_valid are both high in the same cycle, the write completes and RUN starts next cycle.
- RUN:
  - wr_ready = 0, mem_we = 0.
  - Each cycle: mem_addr = phase[PW-1 -: AW], then phase <= phase + tune, wrapping modulo 2^PW (carry discarded).
  - run = 0 -> DRAIN.
- DRAIN:
  - Lasts exactly RD_LAT+1 cycles (counter) so that every issued read returns.
  - No new addresses; phase holds.
  - Then -> IDLE.
  - run reasserted during DRAIN is ignored until IDLE.
  - Phase is not cleared on stop, so playback resumes phase-continuous.

Sample path:
- A read issued in cycle N returns on mem_qout in N+RD_LAT.
- That value is registered into samp in cycle N+RD_LAT+1 with samp_valid = 1. Total latency 2 cycles with the default RD_LAT = 1.
- A shift register of depth RD_LAT+1 tracks read issues.
- samp holds its value when samp_valid = 0.

Tuning:
- tune_ld may be asserted in any state. The new value is used from the next accumulate cycle.
- tune = 0 -> constant address and a constant stream of valid samples.

Optional Feature:
Macro: DDS_DITHER_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h01 on reset; advances each RUN cycle) supplies dither.
  - Its low min(8, PW-AW) bits are added, zero-extended, to phase before truncation for mem_addr only.
  - The accumulator itself is never dithered.
- Undefined: no LFSR logic; pure truncation.
- The bench must run with both settings. With the macro defined, address-sequence checks allow ±1 LSB.

Decomposition:
- Package sine_dds_pkg:
  - dds_state_e enum {IDLE, RUN, DRAIN}.
  - Default widths PW_DEF = 16, AW_DEF = 8, DW_DEF = 8.
  - LFSR seed/taps constants.
- One natural sub-module: dds_phase_acc. It holds the tuning register, accumulator with wrap and enable, and the optional dither LFSR, and outputs the truncated address.
- FSM, write mux and latency pipe stay in the top level.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with run = 1 -> busy = 0, samp_valid = 0, mem_we = 0, wr_ready = 1, samp = 0.
- Table load: in IDLE write (01,10), (03,30), (06,60), (0A,A0), (0F,F0) back-to-back -> mem_we high 5 consecutive cycles with matching mem_addr/mem_din; wr_ready stays 1.
- Playback:
  - tune = 0x0100, run = 1 -> mem_addr = 00, 01, 02… on consecutive cycles.
  - samp_valid rises 2 cycles after the first address.
  - samp = 00, 10, 00, 30, 00, 00, 60… matching the table.
  - Address wraps FF -> 00 after 256 cycles.
- Fractional tune: tune = 0x0080 -> each address held 2 cycles. A tune_ld of 0x0200 mid-run -> stride 2 from the next cycle.
- Stop/write-block: run falls -> exactly 2 more samp_valid pulses, then busy = 0. wr_valid held during RUN -> wr_ready = 0, no mem_we. Restart continues from the saved phase.
- Reset mid-RUN: rst_n = 0 for 1 cycle -> next cycle state IDLE, mem_addr = 00, no samp_valid pulses from the aborted reads.
